// File: rtl/addr_cs_pkg.sv
// addr_cs_pkg: shared types and constants for the address-decoded chip-select
// controller. This package holds the FSM state type and the err_cnt width.
package addr_cs_pkg;

    // FSM states of the access sequencer.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        ACCESS = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_t;

    // Width of the error counter output.
    localparam int ERR_CNT_W = 8;

endpackage : addr_cs_pkg

// File: rtl/addr_cs_ctrl_if.sv
// addr_cs_ctrl_if: request/config/status bundle between a bus master and the
// chip-select controller. The master drives the request and configuration
// signals. The controller (slave) drives the handshake and status signals.
interface addr_cs_ctrl_if
    import addr_cs_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SEL_W  = 2,
    parameter int WAIT_W = 4
);
    localparam int NUM_CS = 2 ** SEL_W;

    logic                     en;
    logic                     req;
    logic [ADDR_W-1:0]        addr;
    logic [NUM_CS-1:0]        cs_enable;
    logic [NUM_CS*WAIT_W-1:0] wait_cfg;
    logic                     ready;
    logic [NUM_CS-1:0]        cs;
    logic                     done;
    logic                     err;
    logic [ERR_CNT_W-1:0]     err_cnt;

    modport master (
        output en, req, addr, cs_enable, wait_cfg,
        input  ready, cs, done, err, err_cnt
    );

    modport slave (
        input  en, req, addr, cs_enable, wait_cfg,
        output ready, cs, done, err, err_cnt
    );

endinterface : addr_cs_ctrl_if

// File: rtl/cs_wait_counter.sv
// cs_wait_counter: wait-state down-counter. The counter is loaded when a
// region is selected. It decrements while the access is in progress. It
// stops at zero and reports that through a zero flag.
module cs_wait_counter #(
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [WAIT_W-1:0] i_load_val,
    input  logic              i_dec,
    output logic              o_zero
);

    logic [WAIT_W-1:0] r_count;

    // Load, or count down toward zero and hold there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule : cs_wait_counter

// File: rtl/addr_cs_ctrl.sv
// addr_cs_ctrl: the top address bits of a request select one of NUM_CS
// regions. An enabled region gets a registered one-hot chip-select for
// wait+1 cycles, followed by a one-cycle done pulse. A disabled region
// gives a one-cycle err pulse. Dropping en aborts the access silently.
// Optional feature: define ADDR_CS_ERR_CNT_EN to build a saturating error
// counter. Without it, err_cnt is tied to zero.
module addr_cs_ctrl
    import addr_cs_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SEL_W  = 2,
    parameter int WAIT_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    addr_cs_ctrl_if.slave bus
);

    localparam int NUM_CS = 2 ** SEL_W;

    state_t              r_state;
    logic [SEL_W-1:0]    r_sel;
    logic                r_ready;
    logic [NUM_CS-1:0]   r_cs;
    logic                r_done;
    logic                r_err;

    logic                w_region_ok;
    logic [NUM_CS-1:0]   w_onehot;
    logic [WAIT_W-1:0]   w_wait_val;
    logic                w_load;
    logic                w_dec;
    logic                w_zero;

    // Region decode from the region index latched with the request.
    assign w_region_ok = bus.cs_enable[r_sel];
    assign w_onehot    = NUM_CS'(1) << r_sel;
    assign w_wait_val  = bus.wait_cfg[r_sel*WAIT_W +: WAIT_W];
    assign w_load      = (r_state == DECODE) && bus.en && w_region_ok;
    assign w_dec       = (r_state == ACCESS) && bus.en;

    cs_wait_counter #(
        .WAIT_W(WAIT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_wait_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // Access sequencer. Every output is registered together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ready <= 1'b1;
            r_cs    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // NOTE: done/err default low here so that each is a single-cycle
            // pulse; non-blocking keeps every branch reading pre-edge values.
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req && bus.en) begin
                        r_sel   <= bus.addr[ADDR_W-1 -: SEL_W];
                        r_ready <= 1'b0;
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    if (!bus.en) begin
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_region_ok) begin
                        r_cs    <= w_onehot;
                        r_state <= ACCESS;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= ERR;
                    end
                end
                ACCESS: begin
                    if (!bus.en) begin
                        r_cs    <= '0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_zero) begin
                        r_cs    <= '0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE, ERR: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_cs    <= '0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready = r_ready;
    assign bus.cs    = r_cs;
    assign bus.done  = r_done;
    assign bus.err   = r_err;

`ifdef ADDR_CS_ERR_CNT_EN
    logic                 w_err_set;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // The counter steps on the same edge that raises err.
    assign w_err_set = (r_state == DECODE) && bus.en && !w_region_ok;

    // Saturating count of err pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_err_set && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.err_cnt = r_err_cnt;
`else
    assign bus.err_cnt = '0;
`endif

endmodule : addr_cs_ctrl

// File: doc/addr_cs_ctrl.md
ADDR_CS_CTRL -- requirements
Module: addr_cs_ctrl

Interface
REQ-001 Parameter ADDR_W, 32, address width in bits.
REQ-002 Parameter SEL_W, 2, number of top address bits decoded; NUM_CS = 2**SEL_W chip-selects.
REQ-003 Parameter WAIT_W, 4, width of the per-region wait-state count.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  global enable; low aborts or blocks any access.
REQ-007 req  input  1  access request, sampled only while ready=1.
REQ-008 addr  input  ADDR_W  access address; captured with req.
REQ-009 cs_enable  input  NUM_CS  per-region enable mask.
REQ-010 wait_cfg  input  NUM_CS*WAIT_W  per-region wait states; region i uses slice i.
REQ-011 ready  output  1  high only in IDLE.
REQ-012 cs  output  NUM_CS  one-hot chip-select, registered.
REQ-013 done  output  1  one-cycle pulse on access completion.
REQ-014 err  output  1  one-cycle pulse on access to a disabled region.
REQ-015 err_cnt  output  8  error count (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, DECODE, ACCESS, DONE, ERR.
REQ-017 In IDLE with req=1 and en=1, the block SHALL latch addr and enter DECODE next cycle; req with en=0 SHALL be ignored.
REQ-018 In DECODE, sel = latched addr[ADDR_W-1 -: SEL_W]; cs_enable[sel]=1 -> ACCESS and load the wait counter with wait_cfg slice sel; otherwise -> ERR.
REQ-019 In ACCESS, cs SHALL equal one-hot(sel); the counter SHALL decrement each cycle; at count 0 -> DONE, so cs is high for wait+1 cycles.
REQ-020 DONE SHALL assert done for exactly one cycle, cs=0, then return to IDLE.
REQ-021 ERR SHALL assert err for exactly one cycle, cs=0, then return to IDLE.
REQ-022 en=0 in DECODE or ACCESS SHALL force IDLE on the next edge, cs=0, with neither done nor err pulsed.
REQ-023 cs_enable and wait_cfg SHALL be sampled only in DECODE; later changes do not affect the current access.
REQ-024 At most one cs bit SHALL be high in any cycle; cs SHALL be 0 in every state except ACCESS.
REQ-025 Minimum request-to-request spacing SHALL be 4 cycles (IDLE, DECODE, ACCESS with wait 0, DONE).

Reset
REQ-026 rst_n low SHALL immediately force IDLE, ready=1, cs=0, done=0, err=0, err_cnt=0, and wait counter=0, independent of clk.
REQ-027 Reset asserted during ACCESS SHALL drop cs asynchronously with no done pulse.

Configuration
REQ-028 With ADDR_CS_ERR_CNT_EN defined, err_cnt SHALL increment on each err pulse and saturate at 255.
REQ-029 Without ADDR_CS_ERR_CNT_EN, err_cnt SHALL be constant 0 and no counter register SHALL be built.

Structure
REQ-030 Package addr_cs_pkg SHALL hold the FSM state type, the state encodings, and the err_cnt width constant (8).
REQ-031 Sub-module cs_wait_counter (load, decrement, zero flag, WAIT_W wide) SHALL implement the wait-state count.

Verification
REQ-032 Reset: rst_n=0 mid-ACCESS -> cs=0 and ready=1 immediately; err_cnt=0.
REQ-033 en=1, req, addr=32'hC000_0000, cs_enable=4'b1111, wait_cfg slice 3 = 2 -> cs=4'b1000 for 3 cycles, then done for 1 cycle, then ready=1.
REQ-034 addr=32'h4000_0000, cs_enable=4'b1101 -> err pulse for 1 cycle, cs stays 0; with macro defined err_cnt=1.
REQ-035 req with en=0 -> no state change, ready stays 1; en dropped during ACCESS -> cs=0 on the next cycle, no done.
REQ-036 Back-to-back requests to regions 0 and 2 with wait 0 -> exactly 4-cycle spacing, each cs one-hot, never overlapping.
REQ-037 With macro defined, 260 error accesses -> err_cnt=255; without macro, err_cnt=0.
